// File: rtl/controlador_de_interrupcao_if.sv
// Signal bundle between the control unit (master) and the interrupt controller (slave).
// The master drives events and handshakes; the slave returns the request and captured state.
interface controlador_de_interrupcao_if #(
    parameter int QUANTUM_WIDTH = 16
);
    logic                     diskDone;
    logic                     ioRequest;
    logic                     userMode;
    logic                     kernelMode;
    logic                     inta;
    logic                     clearIntr;
    logic                     setQuantum;
    logic [QUANTUM_WIDTH-1:0] quantumIn;
    logic [31:0]              pcIn;

    logic                     intr;
    logic [31:0]              intCode;
    logic [31:0]              intPc;
    logic [2:0]               pending;
    logic                     isUser;

    modport master (
        output diskDone, ioRequest, userMode, kernelMode, inta, clearIntr,
               setQuantum, quantumIn, pcIn,
        input  intr, intCode, intPc, pending, isUser
    );

    modport slave (
        input  diskDone, ioRequest, userMode, kernelMode, inta, clearIntr,
               setQuantum, quantumIn, pcIn,
        output intr, intCode, intPc, pending, isUser
    );
endinterface

// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller with sticky pending flags, fixed-priority arbitration
// (disk > io > quantum) and a user-mode quantum timer for preemption.
module controlador_de_interrupcao #(
    parameter int QUANTUM_WIDTH   = 16,
    parameter int DEFAULT_QUANTUM = 100
) (
    input  logic                         clock,
    input  logic                         rst,
    controlador_de_interrupcao_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [QUANTUM_WIDTH-1:0] DEFAULT_Q = QUANTUM_WIDTH'(DEFAULT_QUANTUM);
    localparam logic [QUANTUM_WIDTH-1:0] ONE_Q     = QUANTUM_WIDTH'(1);

    state_t                   state_reg, state_next;
    logic [2:0]               pending_reg, pending_next;
    logic                     is_user_reg, is_user_next;
    logic [1:0]               int_code_reg, int_code_next;
    logic [31:0]              int_pc_reg, int_pc_next;
    logic [QUANTUM_WIDTH-1:0] quantum_reg, quantum_next;
    logic [QUANTUM_WIDTH-1:0] counter_reg, counter_next;

    logic                     accept;
    logic                     release_intr;
    logic [1:0]               accept_code;
    logic [2:0]               accept_mask;
    logic                     dec_en;
    logic                     expiry;
    logic [2:0]               set_vec;
    logic [2:0]               clr_vec;

    // Counter parked at zero never decrements, which is how quantum 0 disables expiry.
    assign dec_en = (state_reg == IDLE) && is_user_reg && (counter_reg != '0);
    assign expiry = dec_en && (counter_reg == ONE_Q);

    always_comb begin
        accept_code = 2'd0;
        accept_mask = 3'b000;
        if (pending_reg[1]) begin
            accept_code = 2'd2;
            accept_mask = 3'b010;
        end else if (pending_reg[2]) begin
            accept_code = 2'd3;
            accept_mask = 3'b100;
        end else if (pending_reg[0]) begin
            accept_code = 2'd1;
            accept_mask = 3'b001;
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        release_intr = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_user_reg && (pending_reg != 3'b000)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.inta) begin
                    accept     = 1'b1;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.clearIntr) begin
                    release_intr = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Set dominates clear so an event landing on its own acceptance edge survives.
    assign set_vec = {bus.ioRequest, bus.diskDone, expiry};
    assign clr_vec = accept ? accept_mask : 3'b000;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pending
            assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        is_user_next = is_user_reg;
        if (accept) begin
            is_user_next = 1'b0;
        end else if (bus.userMode) begin
            is_user_next = 1'b1;
        end else if (bus.kernelMode) begin
            is_user_next = 1'b0;
        end
    end

    always_comb begin
        int_code_next = int_code_reg;
        int_pc_next   = int_pc_reg;
        if (accept) begin
            int_code_next = accept_code;
            int_pc_next   = bus.pcIn;
        end else if (release_intr) begin
            int_code_next = 2'd0;
        end
    end

    always_comb begin
        quantum_next = quantum_reg;
        counter_next = counter_reg;
        if (bus.setQuantum) begin
            quantum_next = bus.quantumIn;
            counter_next = bus.quantumIn;
        end else if (bus.userMode || expiry) begin
            counter_next = quantum_reg;
        end else if (dec_en) begin
            counter_next = counter_reg - ONE_Q;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_reg    <= IDLE;
            pending_reg  <= 3'b000;
            is_user_reg  <= 1'b0;
            int_code_reg <= 2'd0;
            int_pc_reg   <= 32'd0;
            quantum_reg  <= DEFAULT_Q;
            counter_reg  <= DEFAULT_Q;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            is_user_reg  <= is_user_next;
            int_code_reg <= int_code_next;
            int_pc_reg   <= int_pc_next;
            quantum_reg  <= quantum_next;
            counter_reg  <= counter_next;
        end
    end

    assign bus.intr    = (state_reg == REQ);
    assign bus.intCode = {30'd0, int_code_reg};
    assign bus.intPc   = int_pc_reg;
    assign bus.pending = pending_reg;
    assign bus.isUser  = is_user_reg;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Directed bench for controlador_de_interrupcao; accepted interrupts are
// checked against a queue of expected {code, pc} pairs.
module tb_controlador_de_interrupcao;

    logic clock;
    logic rst;
    logic auto_ack;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    controlador_de_interrupcao_if #(.QUANTUM_WIDTH(16)) bus ();

    controlador_de_interrupcao #(
        .QUANTUM_WIDTH  (16),
        .DEFAULT_QUANTUM(100)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    // Control unit model: acknowledge combinationally from intr.
    assign bus.inta = bus.intr & auto_ack;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [31:0] code, input logic [31:0] pc);
        exp_t e;
        e.code = code;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // One clock edge; if it was an acceptance edge, pop the scoreboard and compare.
    task automatic tick();
        logic acc;
        exp_t e;
        @(posedge clock);
        acc = rst && bus.intr && bus.inta;
        @(negedge clock);
        if (acc) begin
            check("sb_expected_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_intCode", bus.intCode, e.code);
                check("sb_intPc", bus.intPc, e.pc);
                $display("accept: intCode=%0d intPc=0x%0h", bus.intCode, bus.intPc);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_intr"},    32'(bus.intr), 32'd0);
        check({tag, "_intCode"}, bus.intCode, 32'd0);
        check({tag, "_intPc"},   bus.intPc, 32'd0);
        check({tag, "_pending"}, 32'(bus.pending), 32'd0);
        check({tag, "_isUser"},  32'(bus.isUser), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        auto_ack       = 1'b1;
        rst            = 1'b0;
        bus.diskDone   = 1'b0;
        bus.ioRequest  = 1'b0;
        bus.userMode   = 1'b0;
        bus.kernelMode = 1'b0;
        bus.clearIntr  = 1'b0;
        bus.setQuantum = 1'b0;
        bus.quantumIn  = '0;
        bus.pcIn       = 32'd0;

        // Reset and a single disk interrupt.
        @(negedge clock);
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b1;
        bus.userMode = 1'b1;
        tick();
        bus.userMode = 1'b0;
        check("t1_isUser", 32'(bus.isUser), 32'd1);
        repeat (7) tick();
        bus.diskDone = 1'b1;
        bus.pcIn     = 32'h40;
        push_exp(32'd2, 32'h40);
        tick();
        bus.diskDone = 1'b0;
        check("t1_pending_after_pulse", 32'(bus.pending), 32'b010);
        check("t1_intr_before_req", 32'(bus.intr), 32'd0);
        tick();
        check("t1_intr_req", 32'(bus.intr), 32'd1);
        tick();
        check("t1_intr_dropped", 32'(bus.intr), 32'd0);
        check("t1_isUser_cleared", 32'(bus.isUser), 32'd0);
        check("t1_pending_cleared", 32'(bus.pending), 32'd0);

        // Disk, io and quantum expiry on the same edge.
        bus.clearIntr  = 1'b1;
        bus.setQuantum = 1'b1;
        bus.quantumIn  = 16'd5;
        tick();
        bus.clearIntr  = 1'b0;
        bus.setQuantum = 1'b0;
        check("t2_intCode_cleared", bus.intCode, 32'd0);
        check("t2_intPc_kept", bus.intPc, 32'h40);
        bus.userMode = 1'b1;
        tick();
        bus.userMode = 1'b0;
        repeat (4) tick();
        bus.diskDone  = 1'b1;
        bus.ioRequest = 1'b1;
        bus.pcIn      = 32'h100;
        tick();
        bus.diskDone  = 1'b0;
        bus.ioRequest = 1'b0;
        check("t2_pending_all", 32'(bus.pending), 32'b111);
        push_exp(32'd2, 32'h100);
        tick();
        check("t2_intr_req", 32'(bus.intr), 32'd1);
        tick();
        check("t2_pending_after_disk", 32'(bus.pending), 32'b101);
        bus.clearIntr = 1'b1;
        bus.userMode  = 1'b1;
        bus.pcIn      = 32'h104;
        tick();
        bus.clearIntr = 1'b0;
        bus.userMode  = 1'b0;
        check("t2_code_zero_between", bus.intCode, 32'd0);
        push_exp(32'd3, 32'h104);
        tick();
        tick();
        check("t2_pending_after_io", 32'(bus.pending), 32'b001);
        bus.clearIntr = 1'b1;
        bus.userMode  = 1'b1;
        bus.pcIn      = 32'h108;
        tick();
        bus.clearIntr = 1'b0;
        bus.userMode  = 1'b0;
        push_exp(32'd1, 32'h108);
        tick();
        tick();
        check("t2_pending_empty", 32'(bus.pending), 32'd0);

        // Quantum of 5 expires exactly 5 cycles after entering user mode.
        bus.clearIntr  = 1'b1;
        bus.setQuantum = 1'b1;
        bus.quantumIn  = 16'd5;
        tick();
        bus.clearIntr  = 1'b0;
        bus.setQuantum = 1'b0;
        bus.userMode   = 1'b1;
        bus.pcIn       = 32'h200;
        tick();
        bus.userMode = 1'b0;
        repeat (4) tick();
        check("t3_no_expiry_at_4", 32'(bus.pending), 32'd0);
        tick();
        check("t3_expiry_at_5", 32'(bus.pending), 32'b001);
        check("t3_intr_not_yet", 32'(bus.intr), 32'd0);
        push_exp(32'd1, 32'h200);
        tick();
        check("t3_intr_next_cycle", 32'(bus.intr), 32'd1);
        tick();

        // Quantum 0 never expires.
        bus.clearIntr  = 1'b1;
        bus.setQuantum = 1'b1;
        bus.quantumIn  = 16'd0;
        tick();
        bus.clearIntr  = 1'b0;
        bus.setQuantum = 1'b0;
        bus.userMode   = 1'b1;
        tick();
        bus.userMode = 1'b0;
        repeat (1000) tick();
        check("t3_q0_pending", 32'(bus.pending), 32'd0);
        check("t3_q0_intr", 32'(bus.intr), 32'd0);
        bus.kernelMode = 1'b1;
        tick();
        bus.kernelMode = 1'b0;
        check("t4_kernel_isUser", 32'(bus.isUser), 32'd0);

        // io request while masked in kernel mode.
        bus.ioRequest = 1'b1;
        tick();
        bus.ioRequest = 1'b0;
        repeat (3) tick();
        check("t4_pending_io", 32'(bus.pending), 32'b100);
        check("t4_intr_masked", 32'(bus.intr), 32'd0);
        bus.userMode = 1'b1;
        bus.pcIn     = 32'h300;
        tick();
        bus.userMode = 1'b0;
        check("t4_intr_not_yet", 32'(bus.intr), 32'd0);
        push_exp(32'd3, 32'h300);
        tick();
        check("t4_intr_rises", 32'(bus.intr), 32'd1);
        tick();
        check("t4_pending_cleared", 32'(bus.pending), 32'd0);

        // Disk event on its own acceptance edge; clearIntr and kernelMode ignored in REQ.
        bus.clearIntr = 1'b1;
        tick();
        bus.clearIntr = 1'b0;
        bus.userMode  = 1'b1;
        tick();
        bus.userMode  = 1'b0;
        auto_ack      = 1'b0;
        bus.diskDone  = 1'b1;
        tick();
        bus.diskDone  = 1'b0;
        tick();
        check("t5_intr_req", 32'(bus.intr), 32'd1);
        bus.clearIntr = 1'b1;
        tick();
        bus.clearIntr = 1'b0;
        check("t5_clear_ignored_in_req", 32'(bus.intr), 32'd1);
        bus.kernelMode = 1'b1;
        tick();
        bus.kernelMode = 1'b0;
        check("t5_kernel_keeps_req", 32'(bus.intr), 32'd1);
        auto_ack     = 1'b1;
        bus.diskDone = 1'b1;
        bus.pcIn     = 32'h400;
        push_exp(32'd2, 32'h400);
        tick();
        bus.diskDone = 1'b0;
        check("t5_disk_flag_kept", 32'(bus.pending), 32'b010);
        check("t5_intr_dropped", 32'(bus.intr), 32'd0);

        // Reset during service of an io interrupt.
        bus.clearIntr = 1'b1;
        bus.userMode  = 1'b1;
        bus.pcIn      = 32'h500;
        tick();
        bus.clearIntr = 1'b0;
        bus.userMode  = 1'b0;
        push_exp(32'd2, 32'h500);
        tick();
        tick();
        check("t6_pending_empty", 32'(bus.pending), 32'd0);
        bus.clearIntr = 1'b1;
        bus.userMode  = 1'b1;
        tick();
        bus.clearIntr = 1'b0;
        bus.userMode  = 1'b0;
        bus.ioRequest = 1'b1;
        bus.pcIn      = 32'h600;
        tick();
        bus.ioRequest = 1'b0;
        push_exp(32'd3, 32'h600);
        tick();
        tick();
        check("t6_in_service_code3", bus.intCode, 32'd3);
        rst = 1'b0;
        tick();
        check_reset_values("t6_reset");
        rst = 1'b1;
        bus.userMode = 1'b1;
        tick();
        bus.userMode = 1'b0;
        repeat (99) tick();
        check("t6_default_q_99", 32'(bus.pending), 32'd0);
        tick();
        check("t6_default_q_100", 32'(bus.pending), 32'b001);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controlador_de_interrupcao.md
# controlador_de_interrupcao

Interrupt controller and preemption scheduler sitting beside `unidade_de_controle`. It collects three asynchronous-to-the-program event sources: disk completion, input request and user-mode quantum expiry. It holds them as sticky pending flags and arbitrates among them by fixed priority. It raises `intr` to the control unit, captures the interrupt code and interrupted PC on acknowledge, and stays masked until the kernel clears the interrupt.

## Interface
- `QUANTUM_WIDTH`, 16, width of quantum register and down-counter
- `DEFAULT_QUANTUM`, 100, quantum loaded at reset
- `clock`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-low
- `diskDone`  in  1  one-cycle pulse: disk transfer finished
- `ioRequest`  in  1  one-cycle pulse: input device requests service
- `userMode`  in  1  exec/exec_again decoded this cycle
- `kernelMode`  in  1  syscall decoded this cycle
- `inta`  in  1  interrupt acknowledge from control unit
- `clearIntr`  in  1  cic decoded: end of interrupt service
- `setQuantum`  in  1  load quantum register
- `quantumIn`  in  QUANTUM_WIDTH  new quantum value
- `pcIn`  in  32  PC of the instruction being preempted
- `intr`  out  1  interrupt request to control unit (registered)
- `intCode`  out  32  accepted interrupt code, zero-extended (read by gic)
- `intPc`  out  32  PC captured at acceptance (read by gip)
- `pending`  out  3  {io, disk, quantum} sticky flags, for kernel polling
- `isUser`  out  1  processor currently in user mode

## Operation
- States: IDLE, REQ, SERVICE.
- Codes: 0 none, 1 quantum, 2 disk, 3 io. Priority disk > io > quantum.
- Pending flags:
  - Set on `diskDone`, on `ioRequest`, or on quantum expiry.
  - Cleared only for the source accepted.
  - If a source's event coincides with its own acceptance, the flag stays set; no event is lost.
- `isUser`:
  - Set by `userMode`.
  - Cleared by `kernelMode` or by acceptance.
  - Acceptance wins over a simultaneous `userMode`.
- Quantum down-counter:
  - Decrements only when state = IDLE and `isUser` = 1.
  - Reloads from the quantum register on `userMode`, on `setQuantum` (with `quantumIn`), and on expiry.
  - Expiry is a decrement from 1 to 0: it sets pending[0] and reloads.
  - Quantum value 0 disables expiry.
  - An expiry while pending[0] is already set has no further effect.
- IDLE → REQ when `isUser` = 1 and any pending flag is set. Interrupts are masked in kernel mode; flags are retained.
- REQ:
  - `intr` = 1 and held until `inta`. `kernelMode` does not cancel the request.
  - On `inta`: latch `intCode` ← highest-priority pending code and `intPc` ← `pcIn`; clear that flag and `isUser`; go to SERVICE.
  - Arbitration is evaluated at the acceptance edge, not at REQ entry.
- SERVICE:
  - `intr` = 0; new events accumulate in pending.
  - On `clearIntr`: `intCode` ← 0 and go to IDLE. `intPc` is kept.
- `clearIntr` in IDLE/REQ and `inta` outside REQ are ignored.

## Timing
- Reset values, applied on any edge with `rst` = 0, including mid-service:
  - state IDLE, `intr` 0, `intCode` 0, `intPc` 0, `pending` 000, `isUser` 0.
  - Quantum register and counter = DEFAULT_QUANTUM.
- Event pulse sampled at edge k → pending visible after k. If `isUser`, state REQ and `intr` = 1 after edge k+1.
- The control unit drives `inta` combinationally from `intr`, so acceptance normally occurs at edge k+2. `intr` drops after that edge.
- `intCode`/`intPc` valid from the cycle after acceptance until cleared (`intCode`) or the next acceptance (`intPc`).
- Quantum of N with uninterrupted user mode: pending[0] set N cycles after the `userMode` edge.
- `setQuantum` and expiry in the same cycle: `setQuantum` wins (reload with `quantumIn`), and pending[0] is still set.

## Test plan
- Reset, then `userMode`, `diskDone` pulse at edge 10, `inta` = `intr`, `pcIn` = 0x40 → `intr` high cycles 11–12, `intCode` = 2, `intPc` = 0x40, `isUser` 0, `pending` 000.
- `diskDone`, `ioRequest` and quantum expiry all in the same cycle in user mode → first acceptance code 2, `pending` = 101. After `clearIntr` and `userMode`, code 3, then code 1 on the following round.
- `setQuantum` with 5, then `userMode`, no other events → pending[0] set exactly 5 cycles later, `intr` next cycle, `intCode` = 1. Quantum 0 → never expires over 1000 cycles.
- Kernel mode (`isUser` 0) with `ioRequest` → `pending` = 100, `intr` stays 0. Later `userMode` → `intr` rises 1 cycle later.
- `diskDone` pulsed exactly at the acceptance edge of a disk interrupt → `intCode` = 2 and pending[1] remains 1. `clearIntr` ignored in REQ.
- `rst` = 0 asserted during SERVICE with `intCode` = 3 → all outputs return to reset values at the next edge. Quantum counter restarts at 100.
